// File: rtl/frame_scheduler.sv
// Frame scheduler: walks the frame in FMA_COUNT-pixel batches, hands each batch to the GPU,
// holds the frame-buffer write address while results drain, then swaps on vertical blank.
module frame_scheduler #(
  parameter int FMA_COUNT = 2,
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 320
) (
  input  logic                                sys_clk_in,
  input  logic                                rst_n_in,
  input  logic                                start_in,
  input  logic                                continuous_in,
  input  logic                                abort_in,
  input  logic                                gpu_ready_in,
  input  logic                                iters_valid_in,
  input  logic                                vsync_in,
  output logic                                batch_valid_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]     batch_addr_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]     addr_write_out,
  output logic                                swap_out,
  output logic                                busy_out,
  output logic [15:0]                         frame_count_out
);

  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int AW     = $clog2(PIXELS);
  localparam int CW     = (FMA_COUNT < 1) ? 1 : $clog2(FMA_COUNT + 1);

  localparam logic [AW:0]   PIXELS_W = PIXELS[AW:0];
  localparam logic [AW:0]   STEP_W   = FMA_COUNT[AW:0];
  localparam logic [CW-1:0] DRAIN_W  = FMA_COUNT[CW-1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_WAIT_VSYNC,
    S_SWAP
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pixel_addr_q, pixel_addr_d;
  logic [AW-1:0]   addr_write_q, addr_write_d;
  logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            abort_pending_q, abort_pending_d;
  logic [15:0]     frame_count_q, frame_count_d;

  logic [AW:0]     next_addr;
  logic            frame_done;
  logic            drain_done;
  logic            abort_seen;

  // Extra bit on the sum so the end-of-frame compare works when PIXELS is a power of two.
  assign next_addr  = {1'b0, pixel_addr_q} + STEP_W;
  assign frame_done = (next_addr == PIXELS_W);
  assign drain_done = (drain_cnt_q == '0);
  assign abort_seen = abort_pending_q | abort_in;

  always_ff @(posedge sys_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= S_IDLE;
      pixel_addr_q    <= '0;
      addr_write_q    <= '0;
      drain_cnt_q     <= '0;
      abort_pending_q <= 1'b0;
      frame_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      pixel_addr_q    <= pixel_addr_d;
      addr_write_q    <= addr_write_d;
      drain_cnt_q     <= drain_cnt_d;
      abort_pending_q <= abort_pending_d;
      frame_count_q   <= frame_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!abort_in && start_in) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (abort_in)          state_d = S_IDLE;
        else if (gpu_ready_in) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (iters_valid_in) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // A deferred abort lands here, once the frame buffer has finished its writes.
        if (drain_done) begin
          if (abort_seen)      state_d = S_IDLE;
          else if (frame_done) state_d = S_WAIT_VSYNC;
          else                 state_d = S_ISSUE;
        end
      end
      S_WAIT_VSYNC: begin
        if (abort_in)      state_d = S_IDLE;
        else if (vsync_in) state_d = S_SWAP;
      end
      S_SWAP: begin
        if (continuous_in && !abort_in) state_d = S_ISSUE;
        else                            state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pixel_addr_d    = pixel_addr_q;
    addr_write_d    = addr_write_q;
    drain_cnt_d     = drain_cnt_q;
    abort_pending_d = abort_pending_q;
    frame_count_d   = frame_count_q;

    if ((state_q == S_IDLE || state_q == S_SWAP) && state_d == S_ISSUE) begin
      pixel_addr_d = '0;
    end

    if (state_q == S_WAIT && iters_valid_in) begin
      addr_write_d = pixel_addr_q;
      drain_cnt_d  = DRAIN_W;
    end

    if (state_q == S_DRAIN) begin
      if (drain_done) pixel_addr_d = next_addr[AW-1:0];
      else            drain_cnt_d  = drain_cnt_q - 1'b1;
    end

    if (state_q == S_SWAP) begin
      frame_count_d = frame_count_q + 16'd1;
    end

    if (state_d == S_IDLE) begin
      abort_pending_d = 1'b0;
    end else if ((state_q == S_WAIT || state_q == S_DRAIN) && abort_in) begin
      abort_pending_d = 1'b1;
    end
  end

  always_comb begin
    batch_valid_out = (state_q == S_ISSUE);
    swap_out        = (state_q == S_SWAP);
    busy_out        = (state_q != S_IDLE);
    batch_addr_out  = pixel_addr_q;
    addr_write_out  = addr_write_q;
    frame_count_out = frame_count_q;
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Randomised bench for frame_scheduler on a 4x2 frame with 2-pixel batches, checked
// cycle by cycle against a frame/batch-level reference model.
module tb_frame_scheduler;

  localparam int FMA = 2;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int NB  = (W * H) / FMA;
  localparam int AW  = $clog2(W * H);
  localparam int NCYC = 4000;

  logic          clk;
  logic          rst_n;
  logic          start, cont, abort, ready, iters, vsync;
  logic          bvalid, swap, busy;
  logic [AW-1:0] baddr, waddr;
  logic [15:0]   fcount;

  frame_scheduler #(.FMA_COUNT(FMA), .WIDTH(W), .HEIGHT(H)) dut (
    .sys_clk_in      (clk),
    .rst_n_in        (rst_n),
    .start_in        (start),
    .continuous_in   (cont),
    .abort_in        (abort),
    .gpu_ready_in    (ready),
    .iters_valid_in  (iters),
    .vsync_in        (vsync),
    .batch_valid_out (bvalid),
    .batch_addr_out  (baddr),
    .addr_write_out  (waddr),
    .swap_out        (swap),
    .busy_out        (busy),
    .frame_count_out (fcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which phase of the frame we are in, which batch is in flight,
  // how many drain cycles remain, and how many frames have been shown.
  typedef enum {M_IDLE, M_REQ, M_RESP, M_FLUSH, M_BLANK, M_FLIP} mphase_t;
  mphase_t m_phase;
  int      m_batch;
  int      m_flush_left;
  int      m_resp_age;
  int      m_wr;
  bit      m_abort;
  int      m_frames;

  task automatic model_reset();
    m_phase = M_IDLE; m_batch = 0; m_flush_left = 0; m_resp_age = 0;
    m_wr = 0; m_abort = 1'b0; m_frames = 0;
  endtask

  task automatic model_step();
    case (m_phase)
      M_IDLE: begin
        m_abort = 1'b0;
        if (!abort && start) begin m_batch = 0; m_phase = M_REQ; end
      end
      M_REQ: begin
        if (abort)      m_phase = M_IDLE;
        else if (ready) begin m_phase = M_RESP; m_resp_age = 0; end
      end
      M_RESP: begin
        if (abort) m_abort = 1'b1;
        if (iters) begin
          m_wr = m_batch * FMA;
          m_flush_left = FMA + 1;
          m_phase = M_FLUSH;
        end else begin
          m_resp_age++;
        end
      end
      M_FLUSH: begin
        if (abort) m_abort = 1'b1;
        m_flush_left--;
        if (m_flush_left == 0) begin
          m_batch++;
          if (m_abort)           begin m_phase = M_IDLE; m_abort = 1'b0; end
          else if (m_batch == NB) m_phase = M_BLANK;
          else                    m_phase = M_REQ;
        end
      end
      M_BLANK: begin
        if (abort)      m_phase = M_IDLE;
        else if (vsync) m_phase = M_FLIP;
      end
      M_FLIP: begin
        m_frames++;
        if (cont && !abort) begin m_batch = 0; m_phase = M_REQ; end
        else                m_phase = M_IDLE;
      end
      default: m_phase = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    chk("batch_valid", bvalid, (m_phase == M_REQ));
    if (m_phase == M_REQ) chk("batch_addr", baddr, m_batch * FMA);
    chk("addr_write", waddr, m_wr);
    chk("swap", swap, (m_phase == M_FLIP));
    chk("busy", busy, (m_phase != M_IDLE));
    chk("frame_count", fcount, m_frames % 65536);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, bvalid, 0);
    chk({tag, "_baddr"}, baddr, 0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_swap"},  swap, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_fcount"}, fcount, 0);
  endtask

  task automatic drive_inputs(input int cyc);
    int seg;
    seg = cyc / 1000;
    case (seg)
      0: begin
        ready = 1'b1;
        iters = (m_phase == M_RESP && m_resp_age >= 1);
        abort = 1'b0;
        cont  = 1'b0;
        start = ($urandom % 4 == 0);
        vsync = ($urandom % 6 == 0);
      end
      1: begin
        ready = $urandom % 2;
        iters = ($urandom % 3 == 0);
        abort = 1'b0;
        cont  = 1'b1;
        start = ($urandom % 4 == 0);
        vsync = ($urandom % 6 == 0);
      end
      default: begin
        ready = (seg == 2) ? ($urandom % 2 == 0) : ($urandom % 4 == 0);
        iters = ($urandom % 3 == 0);
        abort = ($urandom % 15 == 0);
        cont  = $urandom % 2;
        start = ($urandom % 3 == 0);
        vsync = ($urandom % 5 == 0);
      end
    endcase
  endtask

  bit rst_done = 1'b0;

  initial begin
    rst_n = 1'b0;
    start = 0; cont = 0; abort = 0; ready = 0; iters = 0; vsync = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      drive_inputs(cyc);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      if (m_phase == M_FLIP)
        $display("swap: frame %0d shown at cycle %0d", m_frames + 1, cyc);

      // Asynchronous reset dropped between edges while a batch is outstanding.
      if (!rst_done && cyc > 3000 && m_phase == M_RESP) begin
        rst_done = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_reset_values("held_rst");
        model_reset();
        start = 0; abort = 0; iters = 0; vsync = 0;
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        $display("reset: frame in flight discarded at cycle %0d", cyc);
      end
    end

    chk("rst_mid_wait_reached", rst_done, 1);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter FMA_COUNT, default 2: pixels per GPU batch; WIDTH*HEIGHT SHALL be a multiple of FMA_COUNT.
REQ-002 SHALL have parameter WIDTH, default 320: frame columns.
REQ-003 SHALL have parameter HEIGHT, default 320: frame rows.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: sys_clk_in input 1, the single clock; rst_n_in input 1, asynchronous active-low reset.
REQ-005 SHALL have start_in input 1: request to render one frame (sampled in IDLE only).
REQ-006 SHALL have continuous_in input 1: when high, re-render continuously after each swap.
REQ-007 SHALL have abort_in input 1: stop rendering at the next safe point.
REQ-008 SHALL have gpu_ready_in input 1: GPU accepts a batch request.
REQ-009 SHALL have iters_valid_in input 1: GPU batch result pulse, mirrored to the frame buffer.
REQ-010 SHALL have vsync_in input 1: one-cycle vertical-blank pulse, already in sys_clk_in domain.
REQ-011 SHALL have batch_valid_out output 1: batch request valid.
REQ-012 SHALL have batch_addr_out output $clog2(WIDTH*HEIGHT): col-major base pixel index of the requested batch.
REQ-013 SHALL have addr_write_out output $clog2(WIDTH*HEIGHT): frame-buffer write base address.
REQ-014 SHALL have swap_out output 1: one-cycle frame-buffer swap pulse.
REQ-015 SHALL have busy_out output 1: high in every state except IDLE.
REQ-016 SHALL have frame_count_out output 16: completed (swapped) frames, wrapping at 2^16.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, DRAIN, WAIT_VSYNC, SWAP.
REQ-018 IDLE: start_in=1 -> pixel_addr=0, ISSUE; otherwise remain.
REQ-019 ISSUE: batch_valid_out=1, batch_addr_out=pixel_addr; handshake when batch_valid_out&gpu_ready_in -> WAIT next cycle; batch_addr_out stable until handshake.
REQ-020 WAIT: iters_valid_in=1 -> addr_write_out<=pixel_addr, drain counter<=FMA_COUNT, DRAIN; iters_valid_in outside WAIT SHALL be ignored.
REQ-021 DRAIN: hold addr_write_out; count down to 0 (FMA_COUNT+1 cycles in DRAIN total) so the frame buffer finishes its sequential writes; then pixel_addr<=pixel_addr+FMA_COUNT.
REQ-022 DRAIN exit: if pixel_addr+FMA_COUNT == WIDTH*HEIGHT -> WAIT_VSYNC, else ISSUE.
REQ-023 WAIT_VSYNC: vsync_in=1 -> SWAP; vsync_in in other states SHALL be ignored (not latched).
REQ-024 SWAP: swap_out=1 for exactly this one cycle; frame_count_out increments; continuous_in=1 -> pixel_addr=0, ISSUE; else IDLE.
REQ-025 abort_in in IDLE, ISSUE or WAIT_VSYNC SHALL go to IDLE next cycle with no swap; in ISSUE batch_valid_out drops.
REQ-026 abort_in in WAIT or DRAIN SHALL set abort_pending; at DRAIN exit go to IDLE instead of ISSUE/WAIT_VSYNC; abort_pending cleared on entering IDLE.
REQ-027 abort_in in SWAP SHALL complete the swap then go to IDLE regardless of continuous_in.
REQ-028 start_in while busy_out=1 SHALL be ignored.
REQ-029 batch_valid_out SHALL be high only in ISSUE; swap_out only in SWAP.
REQ-030 pixel_addr SHALL never exceed WIDTH*HEIGHT-FMA_COUNT while batch_valid_out=1.

Reset
REQ-031 rst_n_in low SHALL asynchronously force IDLE, pixel_addr=0, addr_write_out=0, batch_addr_out=0, batch_valid_out=0, swap_out=0, busy_out=0, frame_count_out=0, abort_pending=0.
REQ-032 Reset mid-DRAIN or mid-ISSUE SHALL discard the frame in progress; no swap pulse on release.
REQ-033 Deassertion of rst_n_in SHALL take effect on the next sys_clk_in rising edge.

Verification (WIDTH=4, HEIGHT=2, FMA_COUNT=2)
REQ-034 start_in pulse, gpu_ready_in=1, iters_valid_in 2 cycles after each handshake -> batch_addr_out 0,2,4,6; addr_write_out 0,2,4,6; each held 3 DRAIN cycles; then WAIT_VSYNC.
REQ-035 In WAIT_VSYNC, vsync_in pulse -> swap_out high one cycle next cycle, frame_count_out 0->1, IDLE (continuous_in=0).
REQ-036 continuous_in=1, 3 frames -> 3 swap pulses, frame_count_out=3, fourth frame starts at batch_addr_out=0.
REQ-037 gpu_ready_in low 5 cycles in ISSUE -> batch_valid_out held high, batch_addr_out unchanged; early vsync_in during ISSUE/DRAIN -> no swap.
REQ-038 abort_in during DRAIN of batch 2 -> DRAIN completes, IDLE, no further batch_valid_out, swap_out never asserted, frame_count_out unchanged.
REQ-039 rst_n_in low mid-WAIT -> all outputs at reset values immediately (asynchronous), busy_out=0.
